// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   - default WIDTH / DEPTH / N_REQ values
//   - STALL_CNT_W: width of the saturating stall counter
//   - popcount() and rotl() helpers used by the round-robin scan
// The helpers work on a fixed MAX_REQ-bit vector so one function serves
// every requester count up to MAX_REQ; unused upper bits are zero.
package reg_bank_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_N_REQ   = 4;
    localparam int STALL_CNT_W = 16;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = $clog2(MAX_REQ);
    localparam int PC_W    = $clog2(MAX_REQ + 1);

    // Number of set bits in v.
    function automatic logic [PC_W-1:0] popcount(input logic [MAX_REQ-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Rotate the low w bits of v left by n (n may equal w, meaning no
    // rotation). Bits at or above w are returned as zero.
    function automatic logic [MAX_REQ-1:0] rotl(input logic [MAX_REQ-1:0] v,
                                                input int unsigned      n,
                                                input int unsigned      w);
        logic [MAX_REQ-1:0] r;
        int unsigned        s;
        logic [31:0]        idx;
        r = '0;
        s = (n >= w) ? n - w : n;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < w) begin
                idx = i + s;
                if (idx >= w) begin
                    idx = idx - w;
                end
                r[idx[IDX_W-1:0]] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/register.sv
// Basic storage cell: a WIDTH-bit register with synchronous active-high
// reset and no enable. Holding a value is done by feeding o_data_out back
// into i_data_in outside the cell.
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, clears the stored value
//   i_data_in   next value
//   o_data_out  stored value
module register #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_data_out
);

    // NOTE: sequential state is assigned with <= so every flop samples
    // values from before the edge, independent of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_out <= '0;
        end else begin
            o_data_out <= i_data_in;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The scan starts at rr_ptr and wraps modulo N_REQ;
// the first requester found wins and rr_ptr moves just past it.
//   i_clk      clock, rising edge
//   i_rst      synchronous reset; forces all grant outputs low
//   i_req      per-requester request
//   o_gnt      one-hot grant (zero when nothing requests)
//   o_gnt_id   index of the granted requester
//   o_gnt_vld  a grant is issued this cycle
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_gnt_id,
    output logic             o_gnt_vld
);

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [MAX_REQ-1:0] req_rot;
    logic               found;
    logic [IDW-1:0]     ofs;
    logic [IDW:0]       win_sum;
    logic [IDW:0]       nxt_sum;

    // Rotate so that the requester at rr_ptr sits at bit 0, then a plain
    // lowest-set-bit search gives the offset of the winner from rr_ptr.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        req_rot = rotl(MAX_REQ'(i_req), N_REQ - int'(rr_ptr_q), N_REQ);
        found   = 1'b0;
        ofs     = '0;
        for (int j = 0; j < MAX_REQ; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                ofs   = IDW'(j);
            end
        end

        win_sum = {1'b0, rr_ptr_q} + {1'b0, ofs};
        if (win_sum >= (IDW+1)'(N_REQ)) begin
            win_sum = win_sum - (IDW+1)'(N_REQ);
        end
        nxt_sum = win_sum + 1'b1;
        if (nxt_sum >= (IDW+1)'(N_REQ)) begin
            nxt_sum = '0;
        end

        o_gnt     = '0;
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        // Grants are suppressed in a reset cycle so no write can commit.
        if (!i_rst && found) begin
            o_gnt_vld                = 1'b1;
            o_gnt_id                 = win_sum[IDW-1:0];
            o_gnt[win_sum[IDW-1:0]] = 1'b1;
            rr_ptr_d                 = nxt_sum[IDW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared bank of DEPTH registers written by N_REQ requesters through a
// round-robin valid/ack handshake (one write per cycle), with one
// registered read port and a saturating stall counter.
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_req        per-requester write request
//   i_addr       packed write addresses, requester k at [k*AW +: AW]
//   i_wdata      packed write data, requester k at [k*WIDTH +: WIDTH]
//   o_ack        one-hot grant; write of k commits when i_req[k] && o_ack[k]
//   o_gnt_id     index of granted requester (valid with o_gnt_vld)
//   o_gnt_vld    a grant is issued this cycle
//   i_rd_addr    read address
//   o_rd_data    registered read data (0 for out-of-range addresses)
//   o_stall_cnt  saturating count of requester-cycles lost to arbitration
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int N_REQ = DEF_N_REQ,
    localparam int AW    = $clog2(DEPTH),
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*AW-1:0]    i_addr,
    input  logic [N_REQ*WIDTH-1:0] i_wdata,
    output logic [N_REQ-1:0]       o_ack,
    output logic [IDW-1:0]         o_gnt_id,
    output logic                   o_gnt_vld,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   wr_en;
    logic [WIDTH-1:0]       bank_q [DEPTH];
    logic [WIDTH-1:0]       bank_d [DEPTH];
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [PC_W-1:0]        lost;
    logic [STALL_CNT_W:0]   stall_sum;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .o_gnt     (o_ack),
        .o_gnt_id  (o_gnt_id),
        .o_gnt_vld (o_gnt_vld)
    );

    // One-hot select of the winning requester's address and data.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        wr_en   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_req[k] && o_ack[k]) begin
                wr_en   = 1'b1;
                wr_addr = i_addr[k*AW +: AW];
                wr_data = i_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    // The cell has no enable: each register recirculates its own output
    // unless it is the decoded target. An address >= DEPTH matches no
    // cell, so such a write is acked but dropped.
    // NOTE: the bank is cleared by reset inside each cell, because the
    // datapath relies on reading zeros from never-written registers.
    for (genvar g = 0; g < DEPTH; g++) begin : g_bank
        assign bank_d[g] = (wr_en && (wr_addr == AW'(g))) ? wr_data : bank_q[g];

        register #(
            .WIDTH (WIDTH)
        ) u_reg (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_data_in  (bank_d[g]),
            .o_data_out (bank_q[g])
        );
    end

    // Reads see the bank before this cycle's write lands.
    always_comb begin
        rd_data_d = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (i_rd_addr == AW'(a)) begin
                rd_data_d = bank_q[a];
            end
        end
    end

    // Every requesting port except the winner loses this cycle.
    always_comb begin
        lost      = popcount(MAX_REQ'(i_req)) - PC_W'(o_gnt_vld);
        stall_sum = (STALL_CNT_W+1)'(stall_q) + (STALL_CNT_W+1)'(lost);
        stall_d   = stall_sum[STALL_CNT_W] ? '1 : stall_sum[STALL_CNT_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
            stall_q   <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            stall_q   <= stall_d;
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_stall_cnt = stall_q;

endmodule
